// File: rtl/turn_sequencer.sv
// rtl/turn_sequencer.sv - card round sequencer: deal, player turn, dealer turn, resolve
module turn_sequencer #(
  parameter int DEALER_STAND = 17,
  parameter int BUST_LIMIT   = 21,
  parameter int MAX_CARDS    = 5
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_start,
  input  logic       i_cmd_valid,
  input  logic [1:0] i_cmd,
  input  logic [5:0] i_player_sum,
  input  logic [5:0] i_dealer_sum,
  input  logic [2:0] i_player_count,
  input  logic [2:0] i_dealer_count,
  output logic       o_deck_req,
  input  logic       i_card_valid,
  output logic       o_player_load,
  output logic       o_dealer_load,
  output logic       o_hand_clear,
  output logic [1:0] o_turn,
  output logic [2:0] o_state,
  output logic [1:0] o_result
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_DEAL   = 3'd2,
    S_PLAYER = 3'd3,
    S_DEALER = 3'd4,
    S_DRAW   = 3'd5,
    S_SETTLE = 3'd6,
    S_END    = 3'd7   // RESOLVE while result is 00, DONE afterwards
  } state_t;

  // Which phase a DRAW/SETTLE pair belongs to, so SETTLE knows where to return.
  typedef enum logic [1:0] {
    CTX_DEAL   = 2'd0,
    CTX_PLAYER = 2'd1,
    CTX_DEALER = 2'd2
  } ctx_t;

  localparam logic [1:0] CMD_HIT   = 2'b01;
  localparam logic [1:0] CMD_STAND = 2'b10;

  localparam logic [1:0] RES_PLAYER = 2'b01;
  localparam logic [1:0] RES_DEALER = 2'b10;
  localparam logic [1:0] RES_PUSH   = 2'b11;

  localparam logic [5:0] STAND_SUM = 6'(DEALER_STAND);
  localparam logic [5:0] BUST_SUM  = 6'(BUST_LIMIT);
  localparam logic [2:0] CAP_CNT   = 3'(MAX_CARDS);

  state_t     state_q, state_d;
  ctx_t       ctx_q, ctx_d;
  logic [1:0] deal_idx_q, deal_idx_d;
  logic       tgt_dealer_q, tgt_dealer_d;
  logic       deck_req_q, deck_req_d;
  logic       player_load_q, player_load_d;
  logic       dealer_load_q, dealer_load_d;
  logic       hand_clear_q, hand_clear_d;
  logic [1:0] turn_q, turn_d;
  logic [1:0] result_q, result_d;

  // Next-state and next-output logic; every output is derived from the next state so it is registered.
  always_comb begin
    state_d       = state_q;
    ctx_d         = ctx_q;
    deal_idx_d    = deal_idx_q;
    tgt_dealer_d  = tgt_dealer_q;
    result_d      = result_q;
    player_load_d = 1'b0;
    dealer_load_d = 1'b0;
    hand_clear_d  = 1'b0;
    deck_req_d    = 1'b0;
    turn_d        = 2'b00;

    case (state_q)
      S_IDLE: begin
        if (i_start) state_d = S_CLEAR;
      end
      S_CLEAR: begin
        deal_idx_d = 2'd0;
        state_d    = S_DEAL;
      end
      S_DEAL: begin
        // Even deal slots go to the player, odd slots to the dealer.
        ctx_d        = CTX_DEAL;
        tgt_dealer_d = deal_idx_q[0];
        state_d      = S_DRAW;
      end
      S_PLAYER: begin
        if (i_cmd_valid) begin
          if (i_cmd == CMD_HIT) begin
            if (i_player_count < CAP_CNT) begin
              ctx_d        = CTX_PLAYER;
              tgt_dealer_d = 1'b0;
              state_d      = S_DRAW;
            end else begin
              state_d = S_DEALER;
            end
          end else if (i_cmd == CMD_STAND) begin
            state_d = S_DEALER;
          end
        end
      end
      S_DEALER: begin
        if ((i_dealer_sum < STAND_SUM) && (i_dealer_count < CAP_CNT)) begin
          ctx_d        = CTX_DEALER;
          tgt_dealer_d = 1'b1;
          state_d      = S_DRAW;
        end else begin
          state_d = S_END;
        end
      end
      S_DRAW: begin
        // Wait as long as the deck needs; the load pulse lands in the SETTLE cycle.
        if (i_card_valid) begin
          player_load_d = ~tgt_dealer_q;
          dealer_load_d = tgt_dealer_q;
          state_d       = S_SETTLE;
        end
      end
      S_SETTLE: begin
        case (ctx_q)
          CTX_DEAL: begin
            if (deal_idx_q == 2'd3) begin
              state_d = (i_player_sum == BUST_SUM) ? S_DEALER : S_PLAYER;
            end else begin
              deal_idx_d = deal_idx_q + 2'd1;
              state_d    = S_DEAL;
            end
          end
          CTX_PLAYER: begin
            if (i_player_sum > BUST_SUM)
              state_d = S_END;
            else if ((i_player_sum == BUST_SUM) || (i_player_count == CAP_CNT))
              state_d = S_DEALER;
            else
              state_d = S_PLAYER;
          end
          default: state_d = S_DEALER;
        endcase
      end
      S_END: begin
        if (result_q == 2'b00) begin
          if (i_player_sum > BUST_SUM)         result_d = RES_DEALER;
          else if (i_dealer_sum > BUST_SUM)    result_d = RES_PLAYER;
          else if (i_player_sum > i_dealer_sum) result_d = RES_PLAYER;
          else if (i_player_sum < i_dealer_sum) result_d = RES_DEALER;
          else                                  result_d = RES_PUSH;
        end else if (i_start) begin
          state_d = S_CLEAR;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d == S_CLEAR) begin
      hand_clear_d = 1'b1;
      result_d     = 2'b00;
    end

    deck_req_d = (state_d == S_DRAW);

    case (state_d)
      S_PLAYER:          turn_d = 2'b01;
      S_DEALER:          turn_d = 2'b10;
      S_DRAW, S_SETTLE:  turn_d = tgt_dealer_d ? 2'b10 : 2'b01;
      default:           turn_d = 2'b00;
    endcase
  end

  // State and output registers with synchronous reset taking priority over all inputs.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q       <= S_IDLE;
      ctx_q         <= CTX_DEAL;
      deal_idx_q    <= 2'd0;
      tgt_dealer_q  <= 1'b0;
      deck_req_q    <= 1'b0;
      player_load_q <= 1'b0;
      dealer_load_q <= 1'b0;
      hand_clear_q  <= 1'b0;
      turn_q        <= 2'b00;
      result_q      <= 2'b00;
    end else begin
      state_q       <= state_d;
      ctx_q         <= ctx_d;
      deal_idx_q    <= deal_idx_d;
      tgt_dealer_q  <= tgt_dealer_d;
      deck_req_q    <= deck_req_d;
      player_load_q <= player_load_d;
      dealer_load_q <= dealer_load_d;
      hand_clear_q  <= hand_clear_d;
      turn_q        <= turn_d;
      result_q      <= result_d;
    end
  end

  assign o_state       = state_q;
  assign o_deck_req    = deck_req_q;
  assign o_player_load = player_load_q;
  assign o_dealer_load = dealer_load_q;
  assign o_hand_clear  = hand_clear_q;
  assign o_turn        = turn_q;
  assign o_result      = result_q;

endmodule

// File: tb/tb_turn_sequencer.sv
// tb/tb_turn_sequencer.sv - directed self-checking bench for turn_sequencer
module tb_turn_sequencer;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CLEAR  = 3'd1;
  localparam logic [2:0] ST_DEAL   = 3'd2;
  localparam logic [2:0] ST_PLAYER = 3'd3;
  localparam logic [2:0] ST_DEALER = 3'd4;
  localparam logic [2:0] ST_DRAW   = 3'd5;
  localparam logic [2:0] ST_SETTLE = 3'd6;
  localparam logic [2:0] ST_END    = 3'd7;

  logic       clk = 1'b0;
  logic       i_reset = 1'b1;
  logic       i_start = 1'b0;
  logic       i_cmd_valid = 1'b0;
  logic [1:0] i_cmd = 2'b00;
  logic [5:0] i_player_sum = 6'd0;
  logic [5:0] i_dealer_sum = 6'd0;
  logic [2:0] i_player_count = 3'd0;
  logic [2:0] i_dealer_count = 3'd0;
  logic       i_card_valid = 1'b0;
  logic       o_deck_req, o_player_load, o_dealer_load, o_hand_clear;
  logic [1:0] o_turn, o_result;
  logic [2:0] o_state;

  int n_cmp = 0;
  int n_bad = 0;
  int pl_cnt = 0;
  int dl_cnt = 0;
  int hc_cnt = 0;

  always #5 clk = ~clk;

  turn_sequencer dut (
    .i_clk(clk), .i_reset(i_reset), .i_start(i_start),
    .i_cmd_valid(i_cmd_valid), .i_cmd(i_cmd),
    .i_player_sum(i_player_sum), .i_dealer_sum(i_dealer_sum),
    .i_player_count(i_player_count), .i_dealer_count(i_dealer_count),
    .o_deck_req(o_deck_req), .i_card_valid(i_card_valid),
    .o_player_load(o_player_load), .o_dealer_load(o_dealer_load),
    .o_hand_clear(o_hand_clear), .o_turn(o_turn),
    .o_state(o_state), .o_result(o_result)
  );

  always @(posedge clk) begin
    if (o_player_load === 1'b1) pl_cnt <= pl_cnt + 1;
    if (o_dealer_load === 1'b1) dl_cnt <= dl_cnt + 1;
    if (o_hand_clear === 1'b1)  hc_cnt <= hc_cnt + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Deck plus hand model: answer 2 cycles after the request, then update the hand at once.
  task automatic serve_draw(input logic to_dealer, input logic [5:0] new_sum);
    int k;
    k = 0;
    while (o_deck_req !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    n_cmp++;
    if (o_deck_req !== 1'b1) begin
      n_bad++;
      $display("FAIL draw_req_timeout got %b want 1", o_deck_req);
    end
    n_cmp++;
    if (o_turn !== (to_dealer ? 2'b10 : 2'b01)) begin
      n_bad++;
      $display("FAIL draw_turn got %b want %b", o_turn, to_dealer ? 2'b10 : 2'b01);
    end
    tick();
    tick();
    n_cmp++;
    if ({o_deck_req, o_player_load, o_dealer_load, o_state} !== {1'b1, 1'b0, 1'b0, ST_DRAW}) begin
      n_bad++;
      $display("FAIL draw_wait got req=%b pl=%b dl=%b st=%0d want 1 0 0 5",
               o_deck_req, o_player_load, o_dealer_load, o_state);
    end
    i_card_valid = 1'b1;
    tick();
    i_card_valid = 1'b0;
    n_cmp++;
    if ({o_player_load, o_dealer_load, o_deck_req, o_state} !== {~to_dealer, to_dealer, 1'b0, ST_SETTLE}) begin
      n_bad++;
      $display("FAIL draw_load got pl=%b dl=%b req=%b st=%0d want %b %b 0 6",
               o_player_load, o_dealer_load, o_deck_req, o_state, ~to_dealer, to_dealer);
    end
    if (to_dealer) begin
      i_dealer_sum = new_sum;
      i_dealer_count = i_dealer_count + 3'd1;
    end else begin
      i_player_sum = new_sum;
      i_player_count = i_player_count + 3'd1;
    end
  endtask

  task automatic start_round(input logic [5:0] p_sum, input logic [5:0] d_sum, input logic poke_cmd);
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    i_player_sum = 6'd0;
    i_dealer_sum = 6'd0;
    i_player_count = 3'd0;
    i_dealer_count = 3'd0;
    n_cmp++;
    if ({o_state, o_hand_clear, o_result} !== {ST_CLEAR, 1'b1, 2'b00}) begin
      n_bad++;
      $display("FAIL round_clear got st=%0d hc=%b res=%b want 1 1 00", o_state, o_hand_clear, o_result);
    end
    tick();
    n_cmp++;
    if ({o_state, o_hand_clear, o_turn} !== {ST_DEAL, 1'b0, 2'b00}) begin
      n_bad++;
      $display("FAIL round_deal got st=%0d hc=%b turn=%b want 2 0 00", o_state, o_hand_clear, o_turn);
    end
    if (poke_cmd) begin
      i_cmd_valid = 1'b1;
      i_cmd = 2'b10;
    end
    for (int i = 0; i < 4; i++) begin
      serve_draw(i[0], i[0] ? d_sum : p_sum);
      i_cmd_valid = 1'b0;
      tick();
    end
  endtask

  task automatic test_reset();
    i_reset = 1'b1;
    tick();
    tick();
    n_cmp++;
    if ({o_state, o_deck_req, o_player_load, o_dealer_load, o_hand_clear, o_turn, o_result} !== 12'd0) begin
      n_bad++;
      $display("FAIL reset_outputs got st=%0d req=%b pl=%b dl=%b hc=%b turn=%b res=%b want all 0",
               o_state, o_deck_req, o_player_load, o_dealer_load, o_hand_clear, o_turn, o_result);
    end
    i_reset = 1'b0;
    tick();
    n_cmp++;
    if (o_state !== ST_IDLE) begin
      n_bad++;
      $display("FAIL idle_hold got %0d want 0", o_state);
    end
  endtask

  task automatic test_deal();
    int pl0, dl0, hc0;
    pl0 = pl_cnt; dl0 = dl_cnt; hc0 = hc_cnt;
    start_round(6'd12, 6'd10, 1'b1);
    n_cmp++;
    if ({o_state, o_turn} !== {ST_PLAYER, 2'b01}) begin
      n_bad++;
      $display("FAIL deal_end got st=%0d turn=%b want 3 01", o_state, o_turn);
    end
    n_cmp++;
    if ((pl_cnt - pl0) != 2 || (dl_cnt - dl0) != 2 || (hc_cnt - hc0) != 1) begin
      n_bad++;
      $display("FAIL deal_pulses got pl=%0d dl=%0d hc=%0d want 2 2 1", pl_cnt - pl0, dl_cnt - dl0, hc_cnt - hc0);
    end
  endtask

  task automatic test_bust();
    int pl0, dl0;
    pl0 = pl_cnt; dl0 = dl_cnt;
    i_cmd_valid = 1'b1;
    i_cmd = 2'b01;
    tick();
    i_cmd_valid = 1'b0;
    serve_draw(1'b0, 6'd25);
    tick();
    n_cmp++;
    if ({o_state, o_result, o_turn} !== {ST_END, 2'b00, 2'b00}) begin
      n_bad++;
      $display("FAIL bust_resolve got st=%0d res=%b turn=%b want 7 00 00", o_state, o_result, o_turn);
    end
    tick();
    n_cmp++;
    if ({o_state, o_result} !== {ST_END, 2'b10}) begin
      n_bad++;
      $display("FAIL bust_result got st=%0d res=%b want 7 10", o_state, o_result);
    end
    n_cmp++;
    if ((pl_cnt - pl0) != 1 || (dl_cnt - dl0) != 0) begin
      n_bad++;
      $display("FAIL bust_loads got pl=%0d dl=%0d want 1 0", pl_cnt - pl0, dl_cnt - dl0);
    end
  endtask

  task automatic test_dealer_loop(input logic [5:0] p_sum, input logic [1:0] exp_res);
    int dl0;
    start_round(p_sum, 6'd12, 1'b0);
    dl0 = dl_cnt;
    i_cmd_valid = 1'b1;
    i_cmd = 2'b10;
    tick();
    i_cmd_valid = 1'b0;
    n_cmp++;
    if ({o_state, o_turn} !== {ST_DEALER, 2'b10}) begin
      n_bad++;
      $display("FAIL stand_dealer got st=%0d turn=%b want 4 10", o_state, o_turn);
    end
    serve_draw(1'b1, 6'd16);
    tick();
    serve_draw(1'b1, 6'd19);
    tick();
    n_cmp++;
    if (o_state !== ST_DEALER) begin
      n_bad++;
      $display("FAIL dealer_reeval got %0d want 4", o_state);
    end
    tick();
    n_cmp++;
    if ({o_state, o_result, o_deck_req} !== {ST_END, 2'b00, 1'b0}) begin
      n_bad++;
      $display("FAIL dealer_stand got st=%0d res=%b req=%b want 7 00 0", o_state, o_result, o_deck_req);
    end
    tick();
    n_cmp++;
    if (o_result !== exp_res) begin
      n_bad++;
      $display("FAIL dealer_result got %b want %b", o_result, exp_res);
    end
    n_cmp++;
    if ((dl_cnt - dl0) != 2) begin
      n_bad++;
      $display("FAIL dealer_loads got %0d want 2", dl_cnt - dl0);
    end
  endtask

  task automatic test_blackjack();
    start_round(6'd21, 6'd18, 1'b0);
    n_cmp++;
    if ({o_state, o_turn} !== {ST_DEALER, 2'b10}) begin
      n_bad++;
      $display("FAIL bj_dealer got st=%0d turn=%b want 4 10", o_state, o_turn);
    end
    tick();
    tick();
    n_cmp++;
    if ({o_state, o_result} !== {ST_END, 2'b01}) begin
      n_bad++;
      $display("FAIL bj_result got st=%0d res=%b want 7 01", o_state, o_result);
    end
  endtask

  task automatic test_capacity_ignored();
    int pl0, dl0;
    start_round(6'd12, 6'd10, 1'b0);
    pl0 = pl_cnt; dl0 = dl_cnt;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    n_cmp++;
    if ({o_state, o_hand_clear} !== {ST_PLAYER, 1'b0}) begin
      n_bad++;
      $display("FAIL start_ignored got st=%0d hc=%b want 3 0", o_state, o_hand_clear);
    end
    i_card_valid = 1'b1;
    tick();
    i_card_valid = 1'b0;
    tick();
    n_cmp++;
    if ({o_state, o_player_load, o_dealer_load} !== {ST_PLAYER, 1'b0, 1'b0} || pl_cnt != pl0) begin
      n_bad++;
      $display("FAIL stray_card got st=%0d pl=%b dl=%b want 3 0 0", o_state, o_player_load, o_dealer_load);
    end
    i_player_count = 3'd5;
    i_dealer_count = 3'd5;
    i_dealer_sum = 6'd15;
    i_cmd_valid = 1'b1;
    i_cmd = 2'b01;
    tick();
    i_cmd_valid = 1'b0;
    n_cmp++;
    if ({o_state, o_deck_req} !== {ST_DEALER, 1'b0}) begin
      n_bad++;
      $display("FAIL cap_hit got st=%0d req=%b want 4 0", o_state, o_deck_req);
    end
    tick();
    n_cmp++;
    if ({o_state, o_deck_req, o_result} !== {ST_END, 1'b0, 2'b00}) begin
      n_bad++;
      $display("FAIL cap_dealer got st=%0d req=%b res=%b want 7 0 00", o_state, o_deck_req, o_result);
    end
    tick();
    n_cmp++;
    if (o_result !== 2'b10 || pl_cnt != pl0 || dl_cnt != dl0) begin
      n_bad++;
      $display("FAIL cap_result got res=%b pl=%0d dl=%0d want 10 0 0", o_result, pl_cnt - pl0, dl_cnt - dl0);
    end
  endtask

  task automatic test_reset_mid_draw();
    int pl0, dl0;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    tick();
    tick();
    n_cmp++;
    if ({o_state, o_deck_req} !== {ST_DRAW, 1'b1}) begin
      n_bad++;
      $display("FAIL rst_draw_entry got st=%0d req=%b want 5 1", o_state, o_deck_req);
    end
    pl0 = pl_cnt; dl0 = dl_cnt;
    i_card_valid = 1'b1;
    i_reset = 1'b1;
    tick();
    i_card_valid = 1'b0;
    i_reset = 1'b0;
    n_cmp++;
    if ({o_state, o_deck_req, o_player_load, o_dealer_load, o_hand_clear, o_turn, o_result} !== 12'd0) begin
      n_bad++;
      $display("FAIL rst_mid_draw got st=%0d req=%b pl=%b dl=%b hc=%b turn=%b res=%b want all 0",
               o_state, o_deck_req, o_player_load, o_dealer_load, o_hand_clear, o_turn, o_result);
    end
    tick();
    n_cmp++;
    if (pl_cnt != pl0 || dl_cnt != dl0 || o_state !== ST_IDLE) begin
      n_bad++;
      $display("FAIL rst_no_load got pl=%0d dl=%0d st=%0d want 0 0 0", pl_cnt - pl0, dl_cnt - dl0, o_state);
    end
  endtask

  initial begin
    test_reset();
    test_deal();
    test_bust();
    test_dealer_loop(6'd18, 2'b10);
    test_dealer_loop(6'd19, 2'b11);
    test_blackjack();
    test_capacity_ignored();
    test_reset_mid_draw();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
